// File: rtl/mini_processor.sv
// rtl/mini_processor.sv - 8-bit accumulator core with ROM fetch, shared bus and two interrupts
// Optional dereference ops B/C enabled by defining PROC_DEREF_EN.
module mini_processor #(
  parameter logic [7:0] IRQ0_VECTOR = 8'hFF,
  parameter logic [7:0] IRQ1_VECTOR = 8'hFE
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  output logic [7:0] BUS_ADDR,
  output logic       BUS_WE,
  output logic [7:0] ROM_ADDRESS,
  input  logic [7:0] ROM_DATA,
  input  logic [1:0] BUS_INTERRUPTS_RAISE,
  output logic [1:0] BUS_INTERRUPTS_ACK
);

  localparam logic [7:0] S_CHOOSE = 8'h00, S_FETCH  = 8'h01;
  localparam logic [7:0] S_RD_A   = 8'h10, S_RD_B   = 8'h11, S_RD_0 = 8'h12, S_RD_1 = 8'h13, S_RD_2 = 8'h14;
  localparam logic [7:0] S_WR_A   = 8'h20, S_WR_B   = 8'h21, S_WR_0 = 8'h22, S_WR_1 = 8'h23;
  localparam logic [7:0] S_ALU_A  = 8'h30, S_ALU_B  = 8'h31;
  localparam logic [7:0] S_BR_0   = 8'h35, S_BR_1   = 8'h36, S_GO_0 = 8'h38, S_GO_1 = 8'h39;
  localparam logic [7:0] S_CALL_0 = 8'h44, S_CALL_1 = 8'h45, S_RET  = 8'h48;
  localparam logic [7:0] S_DR_0   = 8'h50, S_DR_1   = 8'h51, S_DR_2 = 8'h52;
  localparam logic [7:0] S_IDLE   = 8'hF0, S_IRQ_0  = 8'hF1, S_IRQ_1 = 8'hF2, S_IRQ_2 = 8'hF3;

  logic [7:0] state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, pc_q, pc_d, ctx_q, ctx_d;
  logic [7:0] addr_q, addr_d, dout_q, dout_d, alu_res;
  logic [3:0] aluop_q, aluop_d;
  logic [1:0] ack_q, ack_d;
  logic       we_q, we_d, selb_q, selb_d, irq_q, irq_d;

  assign BUS_DATA           = we_q ? dout_q : 8'hzz;
  assign BUS_ADDR           = addr_q;
  assign BUS_WE             = we_q;
  assign ROM_ADDRESS        = pc_q;
  assign BUS_INTERRUPTS_ACK = ack_q;

  // ALU on the op nibble latched at decode; comparisons yield 1/0
  always_comb begin
    alu_res = 8'h00;
    case (aluop_q)
      4'h0: alu_res = a_q + b_q;
      4'h1: alu_res = a_q - b_q;
      4'h2: alu_res = a_q * b_q;
      4'h3: alu_res = a_q << 1;
      4'h4: alu_res = a_q >> 1;
      4'h5: alu_res = a_q + 8'h01;
      4'h6: alu_res = b_q + 8'h01;
      4'h7: alu_res = a_q - 8'h01;
      4'h8: alu_res = b_q - 8'h01;
      4'h9: alu_res = {7'd0, a_q > b_q};
      4'hA: alu_res = {7'd0, a_q == b_q};
      4'hB: alu_res = {7'd0, a_q < b_q};
      default: alu_res = 8'h00;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_CHOOSE;
      S_CHOOSE: begin
        case (ROM_DATA[3:0])
          4'h0: state_d = S_RD_A;
          4'h1: state_d = S_RD_B;
          4'h2: state_d = S_WR_A;
          4'h3: state_d = S_WR_B;
          4'h4: state_d = S_ALU_A;
          4'h5: state_d = S_ALU_B;
          4'h6: state_d = S_BR_0;
          4'h7: state_d = S_GO_0;
          4'h8: state_d = S_IDLE;
          4'h9: state_d = S_CALL_0;
          4'hA: state_d = S_RET;
`ifdef PROC_DEREF_EN
          4'hB, 4'hC: state_d = S_DR_0;
`endif
          default: state_d = S_FETCH;
        endcase
      end
      S_RD_A, S_RD_B: state_d = S_RD_0;
      S_RD_0:   state_d = S_RD_1;
      S_RD_1:   state_d = S_RD_2;
      S_RD_2:   state_d = S_CHOOSE;
      S_WR_A, S_WR_B: state_d = S_WR_0;
      S_WR_0:   state_d = S_WR_1;
      S_WR_1:   state_d = S_CHOOSE;
      S_ALU_A, S_ALU_B: state_d = S_CHOOSE;
      S_BR_0:   state_d = S_BR_1;
      S_GO_0:   state_d = S_GO_1;
      S_CALL_0: state_d = S_CALL_1;
      S_IDLE:   state_d = (BUS_INTERRUPTS_RAISE != 2'b00) ? S_IRQ_0 : S_IDLE;
      S_IRQ_0:  state_d = S_IRQ_1;
      S_IRQ_1:  state_d = S_IRQ_2;
`ifdef PROC_DEREF_EN
      S_DR_0:   state_d = S_DR_1;
      S_DR_1:   state_d = S_DR_2;
      S_DR_2:   state_d = S_CHOOSE;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath and registered-output next values per state
  always_comb begin
    a_d = a_q; b_d = b_q; pc_d = pc_q; ctx_d = ctx_q;
    addr_d = addr_q; dout_d = dout_q; aluop_d = aluop_q;
    selb_d = selb_q; irq_d = irq_q; we_d = 1'b0; ack_d = 2'b00;
    case (state_q)
      S_CHOOSE: begin
        aluop_d = ROM_DATA[7:4];
        // ops 1/3/5 and C operate on B; all others on A
        selb_d  = (ROM_DATA[3:0] == 4'hC) | ((ROM_DATA[3:0] < 4'h6) & ROM_DATA[0]);
        if (ROM_DATA[3:0] != 4'h8 && ROM_DATA[3:0] != 4'hA) pc_d = pc_q + 8'h01;
      end
      S_RD_0: begin addr_d = ROM_DATA; pc_d = pc_q + 8'h01; end
      S_RD_2: begin
        if (selb_q) b_d = BUS_DATA; else a_d = BUS_DATA;
        addr_d = 8'hFF;
      end
      S_WR_0: begin
        addr_d = ROM_DATA; dout_d = selb_q ? b_q : a_q;
        we_d = 1'b1; pc_d = pc_q + 8'h01;
      end
      S_WR_1:   addr_d = 8'hFF;
      S_ALU_A:  a_d = alu_res;
      S_ALU_B:  b_d = alu_res;
      S_BR_1:   pc_d = (alu_res != 8'h00) ? ROM_DATA : pc_q + 8'h01;
      S_GO_1:   pc_d = ROM_DATA;
      S_CALL_0: ctx_d = pc_q + 8'h01;
      S_CALL_1: pc_d = ROM_DATA;
      S_RET:    pc_d = ctx_q;
      S_IDLE: begin
        // line 0 wins when both are raised
        if (BUS_INTERRUPTS_RAISE[0])      begin ack_d = 2'b01; irq_d = 1'b0; end
        else if (BUS_INTERRUPTS_RAISE[1]) begin ack_d = 2'b10; irq_d = 1'b1; end
      end
      S_IRQ_0: begin ctx_d = pc_q; pc_d = irq_q ? IRQ1_VECTOR : IRQ0_VECTOR; end
      S_IRQ_2:  pc_d = ROM_DATA;
`ifdef PROC_DEREF_EN
      S_DR_0:   addr_d = selb_q ? b_q : a_q;
      S_DR_2: begin
        if (selb_q) b_d = BUS_DATA; else a_d = BUS_DATA;
        addr_d = 8'hFF;
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any access in flight
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      a_q <= 8'h00; b_q <= 8'h00; pc_q <= 8'h00; ctx_q <= 8'h00;
      addr_q <= 8'hFF; dout_q <= 8'h00; aluop_q <= 4'h0;
      selb_q <= 1'b0; irq_q <= 1'b0; we_q <= 1'b0; ack_q <= 2'b00;
    end else begin
      a_q <= a_d; b_q <= b_d; pc_q <= pc_d; ctx_q <= ctx_d;
      addr_q <= addr_d; dout_q <= dout_d; aluop_q <= aluop_d;
      selb_q <= selb_d; irq_q <= irq_d; we_q <= we_d; ack_q <= ack_d;
    end
  end

endmodule

// File: tb/tb_mini_processor.sv
// tb/tb_mini_processor.sv - self-checking bench for mini_processor
module tb_mini_processor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  wire  [7:0] bus_data;
  logic [7:0] bus_addr, rom_addr, rom_data;
  logic       bus_we;
  logic [1:0] raise = 2'b00, ack;

  logic [7:0] rom [256];
  logic [7:0] mem [256];

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t exp_q [$];

  typedef struct { logic [3:0] op; logic dst_b; logic [7:0] a; logic [7:0] b; logic [7:0] exp; } vec_t;
  vec_t vecs [18];

  int n_vec = 0;
  int n_miss = 0;

  mini_processor dut (
    .CLK(clk), .RESET(rst_n), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
    .ROM_ADDRESS(rom_addr), .ROM_DATA(rom_data),
    .BUS_INTERRUPTS_RAISE(raise), .BUS_INTERRUPTS_ACK(ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];
  assign bus_data = bus_we ? 8'hzz : mem[bus_addr];

  // Scoreboard: every write-strobe cycle must match the next expected write
  always @(negedge clk) begin
    if (bus_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_write actual addr=%h data=%h required no write", bus_addr, bus_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus_addr !== e.addr || bus_data !== e.data) begin
          n_miss++;
          $display("FAIL bus_write actual addr=%h data=%h required addr=%h data=%h",
                   bus_addr, bus_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_st(input logic [7:0] s, input string nm);
    for (int i = 0; i < 300 && dut.state_q !== s; i++) tick;
    chk(nm, dut.state_q, s);
  endtask

  task automatic wait_ack(input string nm, input logic [1:0] exp);
    for (int i = 0; i < 30 && ack === 2'b00; i++) tick;
    chk(nm, {6'd0, ack}, {6'd0, exp});
  endtask

  task automatic clear_images;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'h08;
      mem[i] = 8'h00;
    end
    mem[8'hFF] = 8'hA5;
  endtask

  task automatic start;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{4'h0, 1'b0, 8'h05, 8'h03, 8'h08};
    vecs[1]  = '{4'h1, 1'b0, 8'h08, 8'h03, 8'h05};
    vecs[2]  = '{4'h1, 1'b0, 8'h03, 8'h05, 8'hFE};
    vecs[3]  = '{4'h2, 1'b0, 8'h10, 8'h11, 8'h10};
    vecs[4]  = '{4'h3, 1'b0, 8'h81, 8'h00, 8'h02};
    vecs[5]  = '{4'h4, 1'b0, 8'h81, 8'h00, 8'h40};
    vecs[6]  = '{4'h5, 1'b0, 8'hFF, 8'h00, 8'h00};
    vecs[7]  = '{4'h6, 1'b1, 8'h00, 8'hFF, 8'h00};
    vecs[8]  = '{4'h7, 1'b0, 8'h00, 8'h00, 8'hFF};
    vecs[9]  = '{4'h8, 1'b1, 8'h00, 8'h00, 8'hFF};
    vecs[10] = '{4'h9, 1'b0, 8'h08, 8'h03, 8'h01};
    vecs[11] = '{4'h9, 1'b0, 8'h03, 8'h03, 8'h00};
    vecs[12] = '{4'hA, 1'b0, 8'h03, 8'h03, 8'h01};
    vecs[13] = '{4'hA, 1'b0, 8'h03, 8'h04, 8'h00};
    vecs[14] = '{4'hB, 1'b0, 8'h02, 8'h03, 8'h01};
    vecs[15] = '{4'hB, 1'b1, 8'h03, 8'h03, 8'h00};
    vecs[16] = '{4'hC, 1'b0, 8'h07, 8'h09, 8'h00};
    vecs[17] = '{4'h0, 1'b1, 8'h05, 8'h03, 8'h08};

    // reset values
    clear_images;
    rst_n = 1'b0;
    tick;
    tick;
    chk("rst_pc", rom_addr, 8'h00);
    chk("rst_bus_addr", bus_addr, 8'hFF);
    chk("rst_we", {7'd0, bus_we}, 8'h00);
    chk("rst_ack", {6'd0, ack}, 8'h00);
    chk("rst_state", dut.state_q, 8'h01);
    chk("rst_a", dut.a_q, 8'h00);
    chk("rst_b", dut.b_q, 8'h00);
    chk("rst_ctx", dut.ctx_q, 8'h00);

    // read then write timing
    clear_images;
    rom[0] = 8'h00; rom[1] = 8'h10; rom[2] = 8'h02; rom[3] = 8'h20;
    mem[8'h10] = 8'h05;
    exp_q.push_back('{8'h20, 8'h05});
    start;
    wait_st(8'h13, "rd_state13");
    chk("rd_addr13", bus_addr, 8'h10);
    tick;
    chk("rd_state14", dut.state_q, 8'h14);
    chk("rd_addr14", bus_addr, 8'h10);
    tick;
    chk("rd_state00", dut.state_q, 8'h00);
    chk("rd_a", dut.a_q, 8'h05);
    chk("rd_pc", rom_addr, 8'h02);
    wait_st(8'h23, "wr_state23");
    chk("wr_we_on", {7'd0, bus_we}, 8'h01);
    tick;
    chk("wr_we_off", {7'd0, bus_we}, 8'h00);
    chk("wr_addr_idle", bus_addr, 8'hFF);
    chk("wr_bus_released", bus_data, 8'hA5);
    wait_st(8'hF0, "wr_idle");
    chk("wr_drain", 8'(exp_q.size()), 8'h00);

    // ALU vector table
    foreach (vecs[i]) begin
      clear_images;
      rom[0] = 8'h00; rom[1] = 8'h10; rom[2] = 8'h01; rom[3] = 8'h11;
      rom[4] = {vecs[i].op, vecs[i].dst_b ? 4'h5 : 4'h4};
      rom[5] = vecs[i].dst_b ? 8'h03 : 8'h02;
      rom[6] = 8'h20;
      mem[8'h10] = vecs[i].a;
      mem[8'h11] = vecs[i].b;
      exp_q.push_back('{8'h20, vecs[i].exp});
      start;
      wait_st(8'hF0, $sformatf("alu_vec%0d_idle", i));
      chk($sformatf("alu_vec%0d_drain", i), 8'(exp_q.size()), 8'h00);
    end

    // branch taken / not taken
    for (int t = 0; t < 2; t++) begin
      clear_images;
      rom[0] = 8'h00; rom[1] = 8'h10; rom[2] = 8'h01; rom[3] = 8'h11;
      rom[4] = 8'h0D; rom[5] = 8'h0D; rom[6] = 8'h96; rom[7] = 8'h01;
      mem[8'h10] = (t == 0) ? 8'h08 : 8'h02;
      mem[8'h11] = 8'h03;
      start;
      wait_st(8'h36, "br_state36");
      tick;
      chk("br_fetch", dut.state_q, 8'h01);
      chk(t == 0 ? "br_taken_pc" : "br_not_taken_pc", rom_addr, (t == 0) ? 8'h01 : 8'h08);
    end

    // call / return
    clear_images;
    rom[0] = 8'h0D; rom[1] = 8'h0D; rom[2] = 8'h0D; rom[3] = 8'h0D;
    rom[4] = 8'h09; rom[5] = 8'h0A; rom[6] = 8'h08; rom[8'h0A] = 8'h0A;
    start;
    wait_st(8'h45, "call_state45");
    tick;
    chk("call_pc", rom_addr, 8'h0A);
    chk("call_ctx", dut.ctx_q, 8'h06);
    wait_st(8'h48, "ret_state48");
    tick;
    chk("ret_pc", rom_addr, 8'h06);
    wait_st(8'hF0, "ret_idle");

    // goto FE then call at FE: context wraps to 00
    clear_images;
    rom[0] = 8'h07; rom[1] = 8'hFE; rom[8'hFE] = 8'h09; rom[8'hFF] = 8'h20;
    start;
    wait_st(8'h45, "callwrap_state45");
    tick;
    chk("callwrap_ctx", dut.ctx_q, 8'h00);
    chk("callwrap_pc", rom_addr, 8'h20);

    // dereference through A (NOP when the feature is absent)
    clear_images;
    rom[0] = 8'h00; rom[1] = 8'h12; rom[2] = 8'h0B; rom[3] = 8'h02; rom[4] = 8'h20;
    mem[8'h12] = 8'h10;
    mem[8'h10] = 8'h05;
`ifdef PROC_DEREF_EN
    exp_q.push_back('{8'h20, 8'h05});
`else
    exp_q.push_back('{8'h20, 8'h10});
`endif
    start;
    wait_st(8'hF0, "deref_idle");
    chk("deref_drain", 8'(exp_q.size()), 8'h00);

    // idle and interrupts
    clear_images;
    rom[0] = 8'h08; rom[8'hFF] = 8'h30; rom[8'hFE] = 8'h40;
    rom[8'h30] = 8'h08; rom[8'h40] = 8'h08;
    start;
    wait_st(8'hF0, "idle_enter");
    tick; tick; tick;
    chk("idle_held", dut.state_q, 8'hF0);
    chk("idle_pc", rom_addr, 8'h00);
    raise = 2'b01;
    wait_ack("irq0_ack", 2'b01);
    raise = 2'b00;
    tick;
    chk("irq0_ack_clear", {6'd0, ack}, 8'h00);
    wait_st(8'h01, "irq0_fetch");
    chk("irq0_pc", rom_addr, 8'h30);
    chk("irq0_ctx", dut.ctx_q, 8'h00);
    wait_st(8'hF0, "irq0_idle");
    raise = 2'b11;
    wait_ack("irq_both_ack", 2'b01);
    raise = 2'b00;
    wait_st(8'h01, "irq_both_fetch");
    chk("irq_both_pc", rom_addr, 8'h30);
    chk("irq_both_ctx", dut.ctx_q, 8'h30);
    wait_st(8'hF0, "irq_both_idle");
    raise = 2'b10;
    wait_ack("irq1_ack", 2'b10);
    raise = 2'b00;
    wait_st(8'h01, "irq1_fetch");
    chk("irq1_pc", rom_addr, 8'h40);

    // reset during write setup drops the write
    clear_images;
    rom[0] = 8'h02; rom[1] = 8'h20;
    start;
    wait_st(8'h22, "rstwr_state22");
    rst_n = 1'b0;
    #1;
    chk("rstwr_we", {7'd0, bus_we}, 8'h00);
    chk("rstwr_state", dut.state_q, 8'h01);
    chk("rstwr_addr", bus_addr, 8'hFF);
    rom[0] = 8'h08;
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick;
    chk("rstwr_no_write", {7'd0, bus_we}, 8'h00);
    chk("final_drain", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
